// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register scoreboard.
// Each register carries a saturating count of in-flight producers. Issues
// increment it, writebacks decrement it, and flush discards all of them.
// Read ports are combinational and can optionally forward same-cycle
// writeback data (and the matching busy-clear) to consumers.
//
// Issue handshake: an issue transfers on a rising clk edge when
// iss_valid && iss_ready && !flush. iss_ready is a combinational function of
// the scoreboard state and the same-cycle writeback only, never of
// iss_valid, so a requester may hold iss_valid while waiting for iss_ready.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int IDXW   = 5,
  parameter int NRD    = 2,
  parameter int CNTW   = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*IDXW-1:0]  ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rbusy,
  input  logic                 we,
  input  logic [IDXW-1:0]      wa,
  input  logic [XLEN-1:0]      wd,
  input  logic                 iss_valid,
  input  logic [IDXW-1:0]      iss_rd,
  output logic                 iss_ready,
  input  logic                 flush,
  output logic                 wb_err
);

  localparam logic [CNTW-1:0] CMAX = '1;

  logic [XLEN-1:0] rf  [NREG];
  logic [CNTW-1:0] cnt [NREG];
  logic [IDXW-1:0] ra_idx [NRD];
  logic [NREG-1:0] inc_v;
  logic [NREG-1:0] dec_v;
  logic            wb_v;
  logic            iss_idx_ok;
  logic            iss_acc;
  logic            wb_err_d;

  // x0 and indices past the end of the file are never stored or tracked.
  function automatic logic idx_ok(input logic [IDXW-1:0] idx);
    return (idx != '0) && (int'(idx) < NREG);
  endfunction

  genvar g;
  for (g = 0; g < NRD; g++) begin : g_ra
    assign ra_idx[g] = ra[g*IDXW +: IDXW];
  end

  assign wb_v       = we && idx_ok(wa);
  assign iss_idx_ok = idx_ok(iss_rd);

  // A saturated counter can only accept a new producer if a writeback to the
  // same register retires one in the same cycle.
  always_comb begin
    iss_ready = 1'b1;
    if (iss_idx_ok && (cnt[iss_rd] == CMAX) && !(wb_v && (wa == iss_rd)))
      iss_ready = 1'b0;
  end

  assign iss_acc = iss_valid && iss_ready && !flush && iss_idx_ok;

  // One-hot per-register increment/decrement requests for this cycle.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (iss_acc) inc_v[iss_rd] = 1'b1;
    if (wb_v)    dec_v[wa]     = 1'b1;
  end

  // Read ports: stored data or forwarded writeback, plus busy status.
  always_comb begin
    logic fwd;
    fwd   = 1'b0;
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      fwd = 1'b0;
      if (idx_ok(ra_idx[i])) begin
        fwd = (BYPASS != 0) && we && (wa == ra_idx[i]);
        rd[i*XLEN +: XLEN] = fwd ? wd : rf[ra_idx[i]];
        rbusy[i] = (cnt[ra_idx[i]] > CNTW'(1)) ||
                   ((cnt[ra_idx[i]] == CNTW'(1)) && !fwd);
      end
    end
  end

  // Register data: writes land regardless of flush or scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else if (wb_v) begin
      rf[wa] <= wd;
    end
  end

  // Producer counters: flush wins, issue+writeback on one register cancel,
  // and both directions saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (flush)
          cnt[r] <= '0;
        else if (inc_v[r] && !dec_v[r] && (cnt[r] != CMAX))
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec_v[r] && !inc_v[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // A writeback nobody was waiting for is flagged for one cycle.
  assign wb_err_d = wb_v && !flush && (cnt[wa] == '0) && !inc_v[wa];

  // Registered error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_err <= 1'b0;
    else       wb_err <= wb_err_d;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector bench for regfile_sb (default parameters).
// Each vector drives one cycle: inputs at negedge, combinational outputs
// checked before the posedge, registered wb_err checked just after it.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        flush;
  logic        wb_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  regfile_sb dut (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rd        (rd),
    .rbusy     (rbusy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .flush     (flush),
    .wb_err    (wb_err)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  ra0, ra1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] rd0, rd1;
    logic [1:0]  rbusy;
    logic        irdy;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [4:0] ra0, input logic [4:0] ra1, input logic we,
    input logic [4:0] wa, input logic [31:0] wd, input logic iv,
    input logic [4:0] ird, input logic fl, input logic [31:0] rd0,
    input logic [31:0] rd1, input logic [1:0] rb, input logic irdy,
    input logic err);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa = wa; v.wd = wd;
    v.iv = iv; v.ird = ird; v.fl = fl; v.rd0 = rd0; v.rd1 = rd1;
    v.rbusy = rb; v.irdy = irdy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    ra = '0; we = 1'b0; wa = '0; wd = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int k);
    @(negedge clk);
    ra = {v.ra1, v.ra0}; we = v.we; wa = v.wa; wd = v.wd;
    iss_valid = v.iv; iss_rd = v.ird; flush = v.fl;
    #2;
    chk("rd0",       k, 64'(rd[31:0]),  64'(v.rd0));
    chk("rd1",       k, 64'(rd[63:32]), 64'(v.rd1));
    chk("rbusy",     k, 64'(rbusy),     64'(v.rbusy));
    chk("iss_ready", k, 64'(iss_ready), 64'(v.irdy));
    exp_q.push_back(v.err);
    @(posedge clk);
    #1;
    chk("wb_err", k, 64'(wb_err), 64'(exp_q.pop_front()));
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_err", -1, 64'(wb_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    //              ra0 ra1 we wa wd            iv ird fl rd0           rd1           rb     irdy err
    tbl.push_back(mk(5,  7, 0, 0, 32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b00, 1, 0)); // 0 idle after reset
    tbl.push_back(mk(5,  6, 1, 5, 32'hDEADBEEF, 0, 0,  0, 32'hDEADBEEF, 32'h0,        2'b00, 1, 1)); // 1 bypass write, no producer
    tbl.push_back(mk(5,  0, 0, 0, 32'h0,        0, 0,  0, 32'hDEADBEEF, 32'h0,        2'b00, 1, 0)); // 2 stored, err one cycle
    tbl.push_back(mk(7,  0, 0, 0, 32'h0,        1, 7,  0, 32'h0,        32'h0,        2'b00, 1, 0)); // 3 issue x7 -> 1
    tbl.push_back(mk(7,  0, 0, 0, 32'h0,        1, 7,  0, 32'h0,        32'h0,        2'b01, 1, 0)); // 4 -> 2
    tbl.push_back(mk(7,  0, 0, 0, 32'h0,        1, 7,  0, 32'h0,        32'h0,        2'b01, 1, 0)); // 5 -> 3
    tbl.push_back(mk(7,  0, 0, 0, 32'h0,        1, 7,  0, 32'h0,        32'h0,        2'b01, 0, 0)); // 6 saturated, refused
    tbl.push_back(mk(7,  0, 1, 7, 32'h77,       1, 7,  0, 32'h77,       32'h0,        2'b01, 1, 0)); // 7 issue+wb at CMAX
    tbl.push_back(mk(7,  0, 0, 0, 32'h0,        0, 7,  0, 32'h77,       32'h0,        2'b01, 0, 0)); // 8 still 3
    tbl.push_back(mk(0,  7, 1, 7, 32'h78,       0, 0,  0, 32'h0,        32'h78,       2'b10, 1, 0)); // 9 3->2
    tbl.push_back(mk(0,  7, 1, 7, 32'h79,       0, 0,  0, 32'h0,        32'h79,       2'b10, 1, 0)); // 10 2->1
    tbl.push_back(mk(0,  7, 1, 7, 32'h7A,       0, 0,  0, 32'h0,        32'h7A,       2'b00, 1, 0)); // 11 1->0, busy cleared
    tbl.push_back(mk(0,  3, 0, 0, 32'h0,        1, 3,  0, 32'h0,        32'h0,        2'b00, 1, 0)); // 12 issue x3
    tbl.push_back(mk(0,  3, 0, 0, 32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b10, 1, 0)); // 13 x3 busy
    tbl.push_back(mk(0,  3, 1, 3, 32'h33,       0, 0,  0, 32'h0,        32'h33,       2'b00, 1, 0)); // 14 wb clears busy
    tbl.push_back(mk(0,  3, 0, 0, 32'h0,        0, 0,  0, 32'h0,        32'h33,       2'b00, 1, 0)); // 15
    tbl.push_back(mk(0,  3, 1, 3, 32'h34,       0, 0,  0, 32'h0,        32'h34,       2'b00, 1, 1)); // 16 cnt was 0
    tbl.push_back(mk(9,  0, 1, 9, 32'h99,       0, 0,  0, 32'h99,       32'h0,        2'b00, 1, 1)); // 17 x9 orphan wb
    tbl.push_back(mk(9,  0, 0, 0, 32'h0,        0, 0,  0, 32'h99,       32'h0,        2'b00, 1, 0)); // 18 pulse ended
    tbl.push_back(mk(9,  0, 1, 9, 32'h9A,       1, 9,  0, 32'h9A,       32'h0,        2'b00, 1, 0)); // 19 issue+wb x9
    tbl.push_back(mk(9,  0, 1, 9, 32'h9B,       0, 0,  0, 32'h9B,       32'h0,        2'b00, 1, 1)); // 20 cnt stayed 0
    tbl.push_back(mk(0,  0, 0, 0, 32'h0,        1, 4,  0, 32'h0,        32'h0,        2'b00, 1, 0)); // 21 x4 -> 1
    tbl.push_back(mk(0,  0, 0, 0, 32'h0,        1, 4,  0, 32'h0,        32'h0,        2'b00, 1, 0)); // 22 x4 -> 2
    tbl.push_back(mk(4,  6, 0, 0, 32'h0,        1, 6,  0, 32'h0,        32'h0,        2'b01, 1, 0)); // 23 x6 -> 1
    tbl.push_back(mk(4,  6, 1, 6, 32'h66,       1, 4,  1, 32'h0,        32'h66,       2'b01, 1, 0)); // 24 flush+issue+wb
    tbl.push_back(mk(4,  6, 0, 0, 32'h0,        0, 0,  0, 32'h0,        32'h66,       2'b00, 1, 0)); // 25 all clear, data kept
    tbl.push_back(mk(9,  0, 1, 9, 32'h9C,       0, 0,  1, 32'h9C,       32'h0,        2'b00, 1, 0)); // 26 flush hides wb_err
    tbl.push_back(mk(4,  0, 1, 4, 32'h44,       0, 0,  0, 32'h44,       32'h0,        2'b00, 1, 1)); // 27 flushed issue not taken
    tbl.push_back(mk(0,  0, 1, 0, 32'hFFFFFFFF, 1, 0,  0, 32'h0,        32'h0,        2'b00, 1, 0)); // 28 x0 write+issue
    tbl.push_back(mk(0,  0, 0, 0, 32'h0,        0, 0,  0, 32'h0,        32'h0,        2'b00, 1, 0)); // 29 x0 still 0
    tbl.push_back(mk(0,  0, 0, 0, 32'h0,        1, 11, 0, 32'h0,        32'h0,        2'b00, 1, 0)); // 30 issue x11
    tbl.push_back(mk(11, 12, 1, 11, 32'hB1,     1, 12, 0, 32'hB1,       32'h0,        2'b00, 1, 0)); // 31 wb x11, issue x12
    tbl.push_back(mk(11, 12, 0, 0, 32'h0,       0, 0,  0, 32'hB1,       32'h0,        2'b10, 1, 0)); // 32 independent update
    tbl.push_back(mk(11, 12, 1, 11, 32'hB2,     0, 0,  0, 32'hB2,       32'h0,        2'b10, 1, 1)); // 33 x11 back at 0

    for (int k = 0; k < tbl.size(); k++) apply_vec(tbl[k], k);

    // Asynchronous reset assertion mid-cycle clears state immediately.
    @(negedge clk);
    drive_idle();
    we = 1'b1; wa = 5'd9; wd = 32'h5A; ra = {5'd0, 5'd9};
    @(posedge clk);
    #1;
    chk("pre_reset_wb_err", 100, 64'(wb_err), 64'd1);
    #1;
    we = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset_wb_err", 101, 64'(wb_err), 64'd0);
    chk("async_reset_rd0",    102, 64'(rd[31:0]), 64'd0);

    // A write held during reset must not land; release mid-cycle with idle inputs.
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'h1234; ra = {5'd0, 5'd5};
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("no_write_in_reset", 103, 64'(rd[31:0]), 64'd0);
    chk("no_err_after_reset", 104, 64'(wb_err), 64'd0);

    // Release mid-cycle with a write pending: it lands on the next edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    we = 1'b1; wa = 5'd5; wd = 32'hCAFE;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    chk("first_edge_write", 105, 64'(rd[31:0]), 64'h0000CAFE);
    chk("first_edge_err",   106, 64'(wb_err), 64'd1);
    chk("first_edge_busy",  107, 64'(rbusy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
